// File: rtl/psram_line_fetcher_pkg.sv
// rtl/psram_line_fetcher_pkg.sv - shared types and widths for the PSRAM line fetch path
package psram_line_fetcher_pkg;

   // Line-buffer address width (pixels per line up to 1024)
   localparam int PIX_W        = 10;
   // PSRAM controller data word width
   localparam int PSRAM_WORD_W = 32;
   // RGB888 pixel width, shared with the line buffers and pixel pipeline
   localparam int RGB_W        = 24;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/psram_line_fetcher.sv
// rtl/psram_line_fetcher.sv - fetch one display line from PSRAM into the line buffer
module psram_line_fetcher
   import psram_line_fetcher_pkg::*;
#(
   parameter int H_ACTIVE    = 800,
   parameter int BURST_WORDS = 32,
   parameter int ADDR_W      = 22,
   parameter int FB_BASE     = 0,
   parameter int LINE_STRIDE = 1024
) (
   input  logic                    clk_psram,
   input  logic                    rst_n,
   input  logic                    line_req,
   input  logic [PIX_W-1:0]        line_num,
   output logic                    busy,
   output logic                    line_done,
   output logic                    req_dropped,
   output logic                    mem_rd_req,
   output logic [ADDR_W-1:0]       mem_rd_addr,
   input  logic                    mem_rd_ack,
   input  logic                    mem_rd_valid,
   input  logic [PSRAM_WORD_W-1:0] mem_rd_data,
   output logic [PIX_W-1:0]        wr_addr,
   output logic [RGB_W-1:0]        wr_data,
   output logic                    wr_en
);

   // One extra bit so the tail of the last burst can count past H_ACTIVE
   localparam int CNT_W  = PIX_W + 1;
   localparam int BIDX_W = PIX_W + 1;
   localparam int BEAT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

   fetch_state_e      state_q, state_d;
   logic [PIX_W-1:0]  line_q, line_d;
   logic [CNT_W-1:0]  pix_q, pix_d;
   logic [BIDX_W-1:0] bidx_q, bidx_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              drop_q, drop_d;
   logic              wr_en_q, wr_en_d;
   logic [PIX_W-1:0]  wr_addr_q, wr_addr_d;
   logic [RGB_W-1:0]  wr_data_q, wr_data_d;

   logic [PIX_W-1:0]  addr_line;
   logic [BIDX_W-1:0] addr_bidx;
   logic [ADDR_W-1:0] addr_sum;
   logic              unused_hi;

   // The top byte of each PSRAM word carries no pixel information
   assign unused_hi = ^mem_rd_data[PSRAM_WORD_W-1:RGB_W];

   // Single address adder: first burst uses the incoming line number, later bursts the latched one.
   // Arithmetic is done at ADDR_W bits so the result wraps modulo 2^ADDR_W by construction.
   assign addr_line = (state_q == ST_IDLE) ? line_num : line_q;
   assign addr_bidx = (state_q == ST_IDLE) ? '0 : bidx_q + BIDX_W'(1);
   assign addr_sum  = ADDR_W'(FB_BASE)
                    + ADDR_W'(addr_line) * ADDR_W'(LINE_STRIDE)
                    + ADDR_W'(addr_bidx) * ADDR_W'(BURST_WORDS);

   // Next-state and datapath control for the fetch sequencer
   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      pix_d     = pix_q;
      bidx_d    = bidx_q;
      beat_d    = beat_q;
      addr_d    = addr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      drop_d    = drop_q | (line_req && (state_q != ST_IDLE));

      unique case (state_q)
         ST_IDLE: begin
            if (line_req) begin
               line_d  = line_num;
               pix_d   = '0;
               bidx_d  = '0;
               addr_d  = addr_sum;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_rd_ack) begin
               beat_d  = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (mem_rd_valid) begin
               pix_d  = pix_q + CNT_W'(1);
               beat_d = beat_q + BEAT_W'(1);
               if (pix_q < CNT_W'(H_ACTIVE)) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = pix_q[PIX_W-1:0];
                  wr_data_d = mem_rd_data[RGB_W-1:0];
               end
               if (beat_q == BEAT_W'(BURST_WORDS - 1)) begin
                  if (pix_d >= CNT_W'(H_ACTIVE)) begin
                     state_d = ST_DONE;
                  end else begin
                     bidx_d  = bidx_q + BIDX_W'(1);
                     addr_d  = addr_sum;
                     state_d = ST_REQ;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any fetch and zeroes every output
   always_ff @(posedge clk_psram or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         line_q    <= '0;
         pix_q     <= '0;
         bidx_q    <= '0;
         beat_q    <= '0;
         addr_q    <= '0;
         drop_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         pix_q     <= pix_d;
         bidx_q    <= bidx_d;
         beat_q    <= beat_d;
         addr_q    <= addr_d;
         drop_q    <= drop_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign line_done   = (state_q == ST_DONE);
   assign mem_rd_req  = (state_q == ST_REQ);
   assign mem_rd_addr = addr_q;
   assign req_dropped = drop_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_psram_line_fetcher.sv
// tb/tb_psram_line_fetcher.sv - randomized self-checking bench for psram_line_fetcher
module tb_psram_line_fetcher;

   localparam int BW = 32;

   logic       clk;
   logic       rst_n;
   logic       line_req [2];
   logic [9:0] line_num [2];
   int         ack_dly;
   int         gap_pct;
   bit         spurious;
   int         n_cmp;
   int         n_fail;

   // wrap-check instance signals
   logic        w_rst_n, w_line_req, w_ack, w_valid;
   logic [9:0]  w_line_num;
   logic [31:0] w_data;
   logic        w_busy, w_done, w_dropped, w_req, w_wr_en;
   logic [11:0] w_addr;
   logic [9:0]  w_wr_addr;
   logic [23:0] w_wr_data;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int H = (g == 0) ? 800 : 100;
      logic        busy, line_done, req_dropped, mem_rd_req, mem_rd_ack, mem_rd_valid, wr_en;
      logic [21:0] mem_rd_addr;
      logic [31:0] mem_rd_data;
      logic [9:0]  wr_addr;
      logic [23:0] wr_data;
      int          wq_addr [$];
      int          wq_data [$];
      int          burst_q [$];
      int          beats_total = 0;
      int          unstable = 0;

      psram_line_fetcher #(
         .H_ACTIVE(H), .BURST_WORDS(BW), .ADDR_W(22), .FB_BASE(0), .LINE_STRIDE(1024)
      ) dut (
         .clk_psram(clk), .rst_n(rst_n),
         .line_req(line_req[g]), .line_num(line_num[g]),
         .busy(busy), .line_done(line_done), .req_dropped(req_dropped),
         .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
         .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
         .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
      );

      // PSRAM read-controller model: delayed ack, gapped beats, data derived from the word address
      initial begin
         int          wait_cnt;
         int          left;
         int          beat;
         bit          waiting;
         logic [21:0] baddr;
         logic [21:0] seen;
         mem_rd_ack   = 1'b0;
         mem_rd_valid = 1'b0;
         mem_rd_data  = '0;
         left = 0; beat = 0; waiting = 0; wait_cnt = 0; baddr = '0; seen = '0;
         forever begin
            @(negedge clk);
            mem_rd_ack   = 1'b0;
            mem_rd_valid = 1'b0;
            mem_rd_data  = $urandom;
            if (!rst_n) begin
               left = 0;
               waiting = 0;
            end else if (left > 0) begin
               if (int'($urandom_range(99)) >= gap_pct) begin
                  mem_rd_valid = 1'b1;
                  mem_rd_data  = {8'($urandom), 24'(baddr + 22'(beat))};
                  beat++;
                  left--;
                  beats_total++;
               end
            end else if (mem_rd_req) begin
               if (!waiting) begin
                  waiting  = 1;
                  seen     = mem_rd_addr;
                  wait_cnt = 0;
               end else if (mem_rd_addr !== seen) begin
                  unstable++;
               end
               if (wait_cnt >= ack_dly) begin
                  mem_rd_ack = 1'b1;
                  waiting    = 0;
                  baddr      = mem_rd_addr;
                  burst_q.push_back(int'(mem_rd_addr));
                  left       = BW;
                  beat       = 0;
               end
               wait_cnt++;
               mem_rd_valid = spurious && ($urandom_range(1) == 1);
            end else begin
               mem_rd_valid = spurious && !busy && ($urandom_range(1) == 1);
            end
         end
      end

      // Line-buffer write monitor
      initial begin
         forever begin
            @(negedge clk);
            if (rst_n && wr_en) begin
               wq_addr.push_back(int'(wr_addr));
               wq_data.push_back(int'(wr_data));
            end
         end
      end
   end

   psram_line_fetcher #(
      .H_ACTIVE(800), .BURST_WORDS(BW), .ADDR_W(12), .FB_BASE('hF00), .LINE_STRIDE(1024)
   ) dut_w (
      .clk_psram(clk), .rst_n(w_rst_n),
      .line_req(w_line_req), .line_num(w_line_num),
      .busy(w_busy), .line_done(w_done), .req_dropped(w_dropped),
      .mem_rd_req(w_req), .mem_rd_addr(w_addr), .mem_rd_ack(w_ack),
      .mem_rd_valid(w_valid), .mem_rd_data(w_data),
      .wr_addr(w_wr_addr), .wr_data(w_wr_data), .wr_en(w_wr_en)
   );

   localparam int O_BUSY = 60, O_DONE = 59, O_DROP = 58, O_REQ = 57;

   function automatic logic [60:0] outs(input int g);
      if (g == 0)
         return {g_inst[0].busy, g_inst[0].line_done, g_inst[0].req_dropped, g_inst[0].mem_rd_req,
                 g_inst[0].wr_en, g_inst[0].mem_rd_addr, g_inst[0].wr_addr, g_inst[0].wr_data};
      return {g_inst[1].busy, g_inst[1].line_done, g_inst[1].req_dropped, g_inst[1].mem_rd_req,
              g_inst[1].wr_en, g_inst[1].mem_rd_addr, g_inst[1].wr_addr, g_inst[1].wr_data};
   endfunction

   function automatic logic obit(input int g, input int b);
      logic [60:0] v;
      v = outs(g);
      return v[b];
   endfunction

   function automatic int nw(input int g);
      return (g == 0) ? g_inst[0].wq_addr.size() : g_inst[1].wq_addr.size();
   endfunction
   function automatic int wa(input int g, input int i);
      return (g == 0) ? g_inst[0].wq_addr[i] : g_inst[1].wq_addr[i];
   endfunction
   function automatic int wd(input int g, input int i);
      return (g == 0) ? g_inst[0].wq_data[i] : g_inst[1].wq_data[i];
   endfunction
   function automatic int nb(input int g);
      return (g == 0) ? g_inst[0].burst_q.size() : g_inst[1].burst_q.size();
   endfunction
   function automatic int ba(input int g, input int i);
      return (g == 0) ? g_inst[0].burst_q[i] : g_inst[1].burst_q[i];
   endfunction
   function automatic int nbeat(input int g);
      return (g == 0) ? g_inst[0].beats_total : g_inst[1].beats_total;
   endfunction
   function automatic int nunst(input int g);
      return (g == 0) ? g_inst[0].unstable : g_inst[1].unstable;
   endfunction

   // Reference: word address of pixel p of line ln, framebuffer at 0 with 1024-word stride
   function automatic int pix_word(input int ln, input int p);
      return (ln * 1024 + p) % (1 << 22);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Fetch one full line on instance g and score bursts, writes and trailing beats
   task automatic run_line(input int g, input int ln, input int h, input bit drop_mid,
                           input bit drop_done, input bit exp_drop, input string tag);
      int  w0, b0, bt0, cyc, nbur, bad;
      bit  mid_done;
      w0 = nw(g); b0 = nb(g); bt0 = nbeat(g);
      nbur = (h + BW - 1) / BW;
      mid_done = 0;
      @(negedge clk);
      line_num[g] = 10'(ln);
      line_req[g] = 1'b1;
      @(negedge clk);
      line_req[g] = 1'b0;
      check({tag, ".busy_start"}, obit(g, O_BUSY), 1);
      check({tag, ".req_start"}, obit(g, O_REQ), 1);
      cyc = 0;
      while (!obit(g, O_DONE) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         line_req[g] = 1'b0;
         if (drop_mid && !mid_done && cyc > 30 && obit(g, O_BUSY) && !obit(g, O_REQ)) begin
            line_req[g] = 1'b1;
            line_num[g] = 10'($urandom);
            mid_done = 1;
         end
      end
      check({tag, ".done_seen"}, obit(g, O_DONE), 1);
      line_req[g] = drop_done;
      @(negedge clk);
      line_req[g] = 1'b0;
      check({tag, ".busy_end"}, obit(g, O_BUSY), 0);
      check({tag, ".done_pulse"}, obit(g, O_DONE), 0);
      check({tag, ".dropped"}, obit(g, O_DROP), exp_drop);
      check({tag, ".bursts"}, nb(g) - b0, nbur);
      bad = -1;
      for (int k = 0; k < nbur && (b0 + k) < nb(g); k++)
         if (bad < 0 && ba(g, b0 + k) != pix_word(ln, k * BW)) bad = k;
      check({tag, ".burst_addr_bad_idx"}, bad, -1);
      check({tag, ".writes"}, nw(g) - w0, h);
      bad = -1;
      for (int p = 0; p < h && (w0 + p) < nw(g); p++)
         if (bad < 0 && (wa(g, w0 + p) != p || wd(g, w0 + p) != pix_word(ln, p))) bad = p;
      check({tag, ".write_bad_idx"}, bad, -1);
      check({tag, ".beats"}, nbeat(g) - bt0, nbur * BW);
   endtask

   initial begin
      int ln, w0, cyc, u0, u1, expa;
      n_cmp = 0; n_fail = 0;
      ack_dly = 3; gap_pct = 0; spurious = 0;
      rst_n = 1'b0; w_rst_n = 1'b0;
      line_req[0] = 1'b0; line_req[1] = 1'b0; line_num[0] = '0; line_num[1] = '0;
      w_line_req = 1'b0; w_line_num = '0; w_ack = 1'b0; w_valid = 1'b0; w_data = '0;
      repeat (3) @(negedge clk);
      check("reset.outs0", outs(0), 0);
      check("reset.outs1", outs(1), 0);
      check("reset.outs_w", {w_busy, w_done, w_dropped, w_req, w_wr_en, w_addr, w_wr_addr, w_wr_data}, 0);
      rst_n = 1'b1; w_rst_n = 1'b1;

      // address wrap at ADDR_W=12, FB_BASE=0xF00
      for (int i = 0; i < 4; i++) begin
         ln = (i == 0) ? 3 : int'($urandom_range(1023));
         expa = ('hF00 + ln * 1024) % 4096;
         @(negedge clk); w_rst_n = 1'b0;
         @(negedge clk); w_rst_n = 1'b1;
         @(negedge clk); w_line_num = 10'(ln); w_line_req = 1'b1;
         @(negedge clk); w_line_req = 1'b0;
         check("wrap.req", w_req, 1);
         check("wrap.addr0", w_addr, expa);
         repeat (5) @(negedge clk);
         check("wrap.hold", w_addr, expa);
         w_ack = 1'b1;
         @(negedge clk); w_ack = 1'b0; w_valid = 1'b1; w_data = $urandom;
         repeat (BW) @(negedge clk);
         w_valid = 1'b0;
         check("wrap.req1", w_req, 1);
         check("wrap.addr1", w_addr, (expa + BW) % 4096);
      end

      run_line(0, 5, 800, 0, 0, 0, "basic");
      run_line(1, int'($urandom_range(1023)), 100, 0, 0, 0, "partial");

      // back-to-back: request accepted in the first idle cycle after done
      run_line(1, int'($urandom_range(1023)), 100, 0, 0, 0, "b2b");

      run_line(0, int'($urandom_range(1023)), 800, 1, 1, 1, "dropped");
      check("dropped.other_inst", obit(1, O_DROP), 0);

      ack_dly = 20; gap_pct = 40; spurious = 1;
      u0 = nunst(0); u1 = nunst(1);
      run_line(0, int'($urandom_range(1023)), 800, 0, 0, 1, "stall0");
      run_line(1, int'($urandom_range(1023)), 100, 0, 0, 0, "stall1");
      check("stall0.addr_stable", nunst(0) - u0, 0);
      check("stall1.addr_stable", nunst(1) - u1, 0);
      check("sticky.dropped", obit(0, O_DROP), 1);

      // reset around beat 10 of burst 2
      ack_dly = 2; gap_pct = 0; spurious = 0;
      w0 = nw(0);
      @(negedge clk); line_num[0] = 10'($urandom); line_req[0] = 1'b1;
      @(negedge clk); line_req[0] = 1'b0;
      cyc = 0;
      while ((nw(0) - w0) < 75 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      check("rstmid.reached", (nw(0) - w0) >= 75, 1);
      rst_n = 1'b0;
      #1;
      check("rstmid.outs0", outs(0), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rstmid.idle", obit(0, O_BUSY), 0);
      run_line(0, int'($urandom_range(1023)), 800, 0, 0, 0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/psram_line_fetcher.md
# psram_line_fetcher

Fetches one display line of RGB888 pixels from the PSRAM framebuffer and writes it into the write port of the double line buffer. Sits in the PSRAM clock domain between the PSRAM read controller (upstream) and the line buffers (downstream). Issues fixed-length read bursts and streams returned words into consecutive line-buffer addresses. Signals completion so the pixel side can swap buffers.

## Interface
- `H_ACTIVE`, 800: pixels per line; must be ≤ 1024.
- `BURST_WORDS`, 32: words per PSRAM read burst; power of two.
- `ADDR_W`, 22: PSRAM word-address width.
- `FB_BASE`, 0: framebuffer base word address.
- `LINE_STRIDE`, 1024: words between consecutive line starts.

Ports:
- `clk_psram` in 1: sole clock; the PSRAM controller clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `line_req` in 1: one-cycle pulse that starts a fetch of `line_num`.
- `line_num` in 10: line index; sampled when `line_req` is accepted.
- `busy` out 1: a fetch is in progress.
- `line_done` out 1: one-cycle pulse; the line is completely written.
- `req_dropped` out 1: sticky flag; a `line_req` arrived while `busy`.
- `mem_rd_req` out 1: burst read request; held until acknowledged.
- `mem_rd_addr` out ADDR_W: burst start word address.
- `mem_rd_ack` in 1: controller accepted the request.
- `mem_rd_valid` in 1: read data beat valid.
- `mem_rd_data` in 32: read word; bits [23:0] hold the RGB888 pixel.
- `wr_addr` out 10: line-buffer write address.
- `wr_data` out 24: line-buffer write data.
- `wr_en` out 1: line-buffer write strobe.

## Operation
- States: IDLE, REQ, DATA, DONE.
- **IDLE:**
  - `line_req` latches `line_num`.
  - Clears the pixel counter `pix` and burst index `bidx`.
  - Next state is REQ.
- **REQ:**
  - `mem_rd_req`=1.
  - `mem_rd_addr` = (FB_BASE + line·LINE_STRIDE + bidx·BURST_WORDS) mod 2^ADDR_W.
  - Address and request are held stable until `mem_rd_ack`=1.
  - On ack, clear the beat counter and go to DATA; `mem_rd_req` drops the next cycle.
- **DATA:**
  - Each `mem_rd_valid` beat is accepted; there is no backpressure.
  - If `pix` < H_ACTIVE, the beat is written: `wr_addr`=`pix`, `wr_data`=`mem_rd_data[23:0]`.
  - Beats with `pix` ≥ H_ACTIVE (tail of the last burst) are consumed and discarded.
  - Every accepted beat increments `pix` and the beat counter.
  - On beat BURST_WORDS−1:
    - if `pix`+1 ≥ H_ACTIVE, go to DONE;
    - otherwise increment `bidx` and go to REQ.
- **DONE:** one cycle; `line_done`=1, then IDLE.
- `busy`=1 in REQ, DATA and DONE.
- `line_req` while `busy` (including the DONE cycle) is ignored and sets `req_dropped`. Only reset clears `req_dropped`.
- `mem_rd_valid` in IDLE or REQ is ignored: no write and no counter change.
- Number of bursts per line = ceil(H_ACTIVE / BURST_WORDS).
- `line_num` beyond the framebuffer is not checked; the address simply wraps modulo 2^ADDR_W.
- Reset (any state, mid-burst included):
  - returns to IDLE;
  - all outputs go to 0: `busy`, `line_done`, `req_dropped`, `mem_rd_req`, `mem_rd_addr`, `wr_addr`, `wr_data`, `wr_en`.
  - The PSRAM controller shares `rst_n`, so no burst survives reset.

## Timing
- `line_req` at cycle t → `busy`=1 and `mem_rd_req`=1 at t+1.
- `mem_rd_ack` at cycle a → `mem_rd_req`=0 at a+1.
- The earliest data beat is accepted at a+1.
- `wr_en`/`wr_addr`/`wr_data` are registered: a beat at cycle v produces its write at v+1.
- Final beat at cycle f:
  - last `wr_en` (if written) and `line_done` both occur at f+1;
  - `busy`=0 at f+2;
  - a new `line_req` is accepted from f+2 onward.
- Between bursts: the last beat at f leads to `mem_rd_req`=1 at f+1 with the next address.
- No combinational path from any input to any output.

## Structure
- Shared package holds:
  - the state enum;
  - `PIX_W`=10 and `PSRAM_WORD_W`=32;
  - the RGB888 pixel width (24), also used by the line buffers and the pixel pipeline.
- No sub-module. Address generation is one registered adder (base + line·stride + bidx·burst).
  - When LINE_STRIDE and BURST_WORDS are powers of two, the multiplies reduce to shifts.

## Test plan
- **Basic line:** H_ACTIVE=800, BURST=32, `line_req` with `line_num`=5, ack after 3 cycles, data `mem_rd_data`=pixel index → expect:
  - 25 bursts at addresses 5120 + 32k;
  - 800 writes with `wr_data`=`wr_addr`;
  - one `line_done`, then `busy`=0.
- **Partial last burst:** H_ACTIVE=100, BURST=32 → expect:
  - 4 bursts;
  - exactly 100 writes;
  - 28 trailing beats consumed without `wr_en`.
- **Dropped request:** `line_req` mid-DATA, and a second `line_req` in the DONE cycle → expect:
  - both ignored, fetch unaffected;
  - `req_dropped`=1 until reset.
- **Stalled ack and gapped data:** ack held off 20 cycles, random valid gaps → expect:
  - `mem_rd_addr` stable while waiting for ack;
  - writes contiguous in address, no duplicates or gaps.
- **Address wrap:** ADDR_W=12, FB_BASE=0xF00, `line_num`=3 → expect the first burst address = 0xF00 + 3072 mod 4096 = 0xB00.
- **Reset mid-burst:** `rst_n`=0 during beat 10 of burst 2 → expect:
  - all outputs 0 immediately;
  - after release, a new `line_req` starts again at `bidx` 0, `pix` 0.
